// File: rtl/uart_baud_gen.sv
// Fractional (NCO) UART baud tick generator: oversample, bit-boundary and mid-bit
// strobes, with a glitch-free runtime increment change and start-bit re-phasing.
module uart_baud_gen #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SAMPLE_RATE  = 16,
  parameter int unsigned ACC_WIDTH    = 24,
  parameter int unsigned DEFAULT_BAUD = 115_200
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           enable_in,
  input  logic                           sync_in,
  input  logic                           cfg_valid_in,
  input  logic [ACC_WIDTH-1:0]           cfg_incr_in,
  output logic                           cfg_ready_out,
  output logic                           sample_tick_out,
  output logic                           bit_tick_out,
  output logic                           mid_bit_out,
  output logic [$clog2(SAMPLE_RATE)-1:0] sample_idx_out
);

  localparam int unsigned IDX_W = $clog2(SAMPLE_RATE);

  // Rounded default increment; 64-bit arithmetic keeps baud * rate * 2^W exact.
  localparam logic [63:0] INCR_ROUND =
    (((64'(DEFAULT_BAUD) * 64'(SAMPLE_RATE)) << ACC_WIDTH) + 64'(CLK_HZ / 2)) / 64'(CLK_HZ);
  localparam logic [ACC_WIDTH-1:0] DEFAULT_INCR = ACC_WIDTH'(INCR_ROUND);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLE_RATE - 1);
  localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(SAMPLE_RATE / 2 - 1);

  logic [ACC_WIDTH-1:0] acc_reg;
  logic [ACC_WIDTH-1:0] incr_active_reg;
  logic [ACC_WIDTH-1:0] incr_pending_reg;
  logic                 pend_vld_reg;
  logic [IDX_W-1:0]     sample_idx_reg;
  logic                 sample_tick_reg;
  logic                 bit_tick_reg;
  logic                 mid_bit_reg;

  logic [ACC_WIDTH:0]   sum_next;
  logic                 carry_next;
  logic                 advance_next;
  logic                 bit_tick_next;
  logic                 mid_bit_next;
  logic                 apply_next;
  logic                 accept_next;

  always_comb begin
    sum_next      = {1'b0, acc_reg} + {1'b0, incr_active_reg};
    advance_next  = enable_in && !sync_in;
    carry_next    = advance_next && sum_next[ACC_WIDTH];
    bit_tick_next = carry_next && (sample_idx_reg == IDX_LAST);
    mid_bit_next  = carry_next && (sample_idx_reg == IDX_MID);
    // A new increment only lands where it cannot stretch or shrink a bit in flight.
    apply_next    = pend_vld_reg &&
                    (sync_in || !enable_in || (incr_active_reg == '0) || bit_tick_next);
    accept_next   = cfg_valid_in && !pend_vld_reg;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc_reg          <= '0;
      incr_active_reg  <= DEFAULT_INCR;
      incr_pending_reg <= '0;
      pend_vld_reg     <= 1'b0;
      sample_idx_reg   <= '0;
      sample_tick_reg  <= 1'b0;
      bit_tick_reg     <= 1'b0;
      mid_bit_reg      <= 1'b0;
    end else begin
      sample_tick_reg <= 1'b0;
      bit_tick_reg    <= 1'b0;
      mid_bit_reg     <= 1'b0;

      if (sync_in) begin
        acc_reg        <= '0;
        sample_idx_reg <= '0;
      end else if (enable_in) begin
        acc_reg         <= sum_next[ACC_WIDTH-1:0];
        sample_tick_reg <= carry_next;
        bit_tick_reg    <= bit_tick_next;
        mid_bit_reg     <= mid_bit_next;
        if (carry_next) begin
          sample_idx_reg <= sample_idx_reg + IDX_W'(1);
        end
      end

      // Apply and accept are mutually exclusive: apply needs a full slot, accept an empty one.
      if (apply_next) begin
        incr_active_reg <= incr_pending_reg;
        pend_vld_reg    <= 1'b0;
      end else if (accept_next) begin
        incr_pending_reg <= cfg_incr_in;
        pend_vld_reg     <= 1'b1;
      end
    end
  end

  assign cfg_ready_out   = !pend_vld_reg;
  assign sample_tick_out = sample_tick_reg;
  assign bit_tick_out    = bit_tick_reg;
  assign mid_bit_out     = mid_bit_reg;
  assign sample_idx_out  = sample_idx_reg;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: per-cycle scoreboard fed by a phase-count reference model,
// plus directed timing checks on tick spacing, config handshake, sync, hold and reset.
module tb_uart_baud_gen;

  localparam int SR = 16;
  localparam int AW = 24;
  localparam int IW = 4;
  localparam longint unsigned DEF_INCR = 309_238;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          sync = 1'b0;
  logic          cv = 1'b0;
  logic [AW-1:0] ci = '0;
  logic          cfg_ready_out;
  logic          sample_tick_out;
  logic          bit_tick_out;
  logic          mid_bit_out;
  logic [IW-1:0] sample_idx_out;

  always #5 clk = ~clk;

  uart_baud_gen dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .enable_in       (en),
    .sync_in         (sync),
    .cfg_valid_in    (cv),
    .cfg_incr_in     (ci),
    .cfg_ready_out   (cfg_ready_out),
    .sample_tick_out (sample_tick_out),
    .bit_tick_out    (bit_tick_out),
    .mid_bit_out     (mid_bit_out),
    .sample_idx_out  (sample_idx_out)
  );

  typedef struct packed {
    logic          tick;
    logic          bt;
    logic          mid;
    logic [IW-1:0] idx;
    logic          rdy;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: total phase since last restart; a tick is a change of floor(phase / 2^AW).
  longint unsigned m_phase;
  longint unsigned m_ticks;
  longint unsigned m_incr;
  logic [AW-1:0]   m_pend[$];

  task automatic model_edge();
    exp_t            x;
    longint unsigned np;
    longint unsigned old_incr;
    bit              had_pend;
    bit              apply;
    x = '0;
    if (rst) begin
      m_phase = 0;
      m_ticks = 0;
      m_incr  = DEF_INCR;
      m_pend.delete();
      x.rdy = 1'b1;
    end else begin
      old_incr = m_incr;
      had_pend = (m_pend.size() > 0);
      if (sync) begin
        m_phase = 0;
        m_ticks = 0;
      end else if (en) begin
        np = m_phase + m_incr;
        if ((np >> AW) != (m_phase >> AW)) begin
          x.tick = 1'b1;
          x.bt   = ((m_ticks % SR) == SR - 1);
          x.mid  = ((m_ticks % SR) == SR / 2 - 1);
          m_ticks++;
        end
        m_phase = np;
      end
      apply = had_pend && (sync || !en || old_incr == 0 || x.bt);
      if (apply) m_incr = longint'(m_pend.pop_front());
      else if (cv && !had_pend) m_pend.push_back(ci);
      x.rdy = (m_pend.size() == 0);
    end
    x.idx = IW'(m_ticks % SR);
    sb_q.push_back(x);
  endtask

  task automatic monitor_loop();
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = {sample_tick_out, bit_tick_out, mid_bit_out, sample_idx_out, cfg_ready_out};
        total++;
        if (a !== e) begin
          bad++;
          if (bad <= 12)
            $display("FAIL scoreboard t=%0t actual tick/bit/mid/idx/rdy=%b/%b/%b/%0d/%b required %b/%b/%b/%0d/%b",
                     $time, a.tick, a.bt, a.mid, a.idx, a.rdy, e.tick, e.bt, e.mid, e.idx, e.rdy);
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic s, input logic v,
                      input logic [AW-1:0] c);
    rst = r; en = e; sync = s; cv = v; ci = c;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // sel: 0 sample tick, 1 bit tick, 2 mid-bit. Returns edges taken (limit on timeout).
  task automatic run_until(input int sel, input int limit, output int n);
    logic hit;
    n = 0;
    do begin
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      n++;
      hit = (sel == 0) ? sample_tick_out : (sel == 1) ? bit_tick_out : mid_bit_out;
    end while (!hit && n < limit);
  endtask

  int n;
  int strobes;
  int held_idx;

  initial begin
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("rst_tick", sample_tick_out, 0);
    chk("rst_idx", sample_idx_out, 0);
    chk("rst_ready", cfg_ready_out, 1);

    // Default rate: first tick at edge 55, gaps 54/55, bit period 868/869
    run_until(0, 200, n);
    chk("first_tick", n, 55);
    repeat (4) begin
      run_until(0, 200, n);
      chk_rng("default_gap", n, 54, 55);
    end
    run_until(2, 2000, n);
    chk("mid_idx", sample_idx_out, SR / 2);
    run_until(1, 2000, n);
    run_until(1, 2000, n);
    chk_rng("default_bit_period", n, 868, 869);
    repeat (8000) step(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // 9600 baud offered mid-bit, second offer refused while slot is full
    run_until(2, 2000, n);
    step(1'b0, 1'b1, 1'b0, 1'b1, AW'(25_770));
    chk("cfg_ready_after_accept", cfg_ready_out, 0);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b1, AW'(12_345));
    run_until(1, 2000, n);
    chk("cfg_ready_at_bit_tick", cfg_ready_out, 1);
    run_until(1, 11_000, n);
    run_until(1, 11_000, n);
    chk_rng("slow_bit_period", n, 10_416, 10_417);
    run_until(0, 1000, n);
    chk_rng("slow_gap", n, 651, 652);

    // sync at idx 5 with a pending default increment
    n = 0;
    while (sample_idx_out != 5 && n < 12_000) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      n++;
    end
    chk("sync_wait_idx", sample_idx_out, 5);
    step(1'b0, 1'b1, 1'b0, 1'b1, AW'(DEF_INCR));
    repeat (300) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0);
    chk("sync_idx", sample_idx_out, 0);
    chk("sync_no_tick", sample_tick_out, 0);
    chk("sync_applies_cfg", cfg_ready_out, 1);
    run_until(0, 200, n);
    chk("sync_first_tick", n, 55);

    // Hold for 500 cycles mid-bit with a config offered while disabled
    run_until(2, 2000, n);
    repeat (20) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    held_idx = sample_idx_out;
    strobes  = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b0, 1'b0, 1'b0, (i == 10), AW'(DEF_INCR));
      if (i == 10) chk("hold_ready_low", cfg_ready_out, 0);
      if (i == 11) chk("hold_ready_back", cfg_ready_out, 1);
      strobes += int'(sample_tick_out) + int'(bit_tick_out) + int'(mid_bit_out);
      if (sample_idx_out != held_idx) strobes += 1000;
    end
    chk("hold_frozen", strobes, 0);
    repeat (2000) step(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Zero increment silences everything; 2^23 then ticks every 2 cycles
    step(1'b0, 1'b1, 1'b0, 1'b1, '0);
    run_until(1, 2000, n);
    strobes = 0;
    repeat (10_000) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      strobes += int'(sample_tick_out) + int'(bit_tick_out) + int'(mid_bit_out);
    end
    chk("zero_incr_silent", strobes, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, AW'(1 << 23));
    run_until(0, 100, n);
    run_until(0, 100, n);
    chk("half_gap", n, 2);
    run_until(1, 100, n);
    run_until(1, 100, n);
    chk("half_bit_period", n, 32);

    // Randomized enable / sync / config traffic
    for (int i = 0; i < 15_000; i++) begin
      step(1'b0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0) ? AW'(0) : AW'($urandom_range(1 << 19, 1 << 23)));
    end

    // Reset while a config is pending
    step(1'b0, 1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b1, AW'(25_770));
    chk("pend_before_rst", cfg_ready_out, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("rst_mid_tick", int'(sample_tick_out) + int'(bit_tick_out) + int'(mid_bit_out), 0);
    chk("rst_mid_idx", sample_idx_out, 0);
    chk("rst_mid_ready", cfg_ready_out, 1);
    run_until(0, 200, n);
    chk("post_rst_first_tick", n, 55);
    run_until(0, 200, n);
    chk_rng("post_rst_gap", n, 54, 55);

    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    #10;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
